// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for the alu_seq execute unit.
package alu_seq_pkg;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_SHL  = 6'd2;
    localparam logic [5:0] OP_SHR  = 6'd3;
    localparam logic [5:0] OP_PASS = 6'd4;
    localparam logic [5:0] OP_LDH  = 6'd5;
    localparam logic [5:0] OP_MUL  = 6'd6;
    localparam logic [5:0] OP_CMP  = 6'd7;
    localparam logic [5:0] OP_JMP  = 6'd8;
    localparam logic [5:0] OP_BEQ  = 6'd9;
    localparam logic [5:0] OP_BLT  = 6'd10;
    localparam logic [5:0] OP_BGT  = 6'd11;

    localparam int FLAG_Z  = 0;
    localparam int FLAG_LT = 1;
    localparam int FLAG_GT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, W cycles after start.
// done/product are valid in the cycle of the last iteration so the caller can register them.
module alu_seq_mul #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] product
);
    localparam int CNT_W = $clog2(W);

    logic [W-1:0]     acc_r;
    logic [W-1:0]     mcand_r;
    logic [W-1:0]     mplier_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic [W-1:0]     addend_s;
    logic [W-1:0]     acc_nxt_s;

    // Partial-product accumulation for the current iteration
    always_comb begin
        addend_s = {W{1'b0}};
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {W{1'b0}};
        end
        acc_nxt_s = acc_r + addend_s;
    end

    assign done    = busy_r && (cnt_r == CNT_W'(W - 1));
    assign product = acc_nxt_s;

    // Operand capture at start, then shift/accumulate until the last bit
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_r    <= {W{1'b0}};
            mcand_r  <= {W{1'b0}};
            mplier_r <= {W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
        end else if (start) begin
            acc_r    <= {W{1'b0}};
            mcand_r  <= a;
            mplier_r <= b;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= acc_nxt_s;
            mcand_r  <= {mcand_r[W-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[W-1:1]};
            cnt_r    <= cnt_r + CNT_W'(1);
            busy_r   <= ~done;
        end else begin
            busy_r   <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked W-bit execute unit with compare flags and branch resolution.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier; otherwise op 6 is illegal.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W    = 32,
    parameter int SH_W = $clog2(W) + 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [5:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W/2-1:0] imm,
    input  logic           highlow,
    input  logic [W-1:0]   link,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   result,
    output logic           out_err,
    output logic [2:0]     flags,
    output logic           branch_taken,
    output logic [W-1:0]   branch_addr
);
    state_t         state_r;
    state_t         state_nxt_s;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [W-1:0]   result_r;
    logic           err_r;
    logic [2:0]     flags_r;
    logic           taken_r;
    logic [W-1:0]   baddr_r;

    logic           accept_s;
    logic [W-1:0]   alu_res_s;
    logic           alu_err_s;
    logic           alu_taken_s;
    logic [2:0]     cmp_flags_s;
    logic [SH_W-1:0] shamt_s;

    assign accept_s = in_valid & in_ready_r;
    assign shamt_s  = b[SH_W-1:0];

`ifdef ALU_SEQ_MUL_EN
    logic           mul_start_s;
    logic           mul_done_s;
    logic [W-1:0]   mul_product_s;

    assign mul_start_s = accept_s && (op == OP_MUL);

    alu_seq_mul #(.W(W)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start_s),
        .a       (a),
        .b       (b),
        .done    (mul_done_s),
        .product (mul_product_s)
    );
`endif

    // Single-cycle datapath; shifts fill vacated bits with ones
    always_comb begin
        alu_res_s   = {W{1'b0}};
        alu_err_s   = 1'b0;
        alu_taken_s = 1'b0;
        cmp_flags_s = 3'b000;
        cmp_flags_s[FLAG_GT] = (a > b);
        cmp_flags_s[FLAG_LT] = (a < b);
        cmp_flags_s[FLAG_Z]  = (a == b);
        case (op)
            OP_ADD:  alu_res_s = a + b;
            OP_SUB:  alu_res_s = a - b;
            OP_SHL:  alu_res_s = (a << shamt_s) | ~({W{1'b1}} << shamt_s);
            OP_SHR:  alu_res_s = (a >> shamt_s) | ~({W{1'b1}} >> shamt_s);
            OP_PASS: alu_res_s = a;
            OP_LDH: begin
                if (highlow) begin
                    alu_res_s = {imm, a[W/2-1:0]};
                end else begin
                    alu_res_s = {a[W-1:W/2], imm};
                end
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:  alu_res_s = {W{1'b0}};
`endif
            OP_CMP:  alu_res_s = a;
            OP_JMP:  alu_taken_s = 1'b1;
            OP_BEQ:  alu_taken_s = flags_r[FLAG_Z];
            OP_BLT:  alu_taken_s = flags_r[FLAG_LT];
            OP_BGT:  alu_taken_s = flags_r[FLAG_GT];
            default: alu_err_s = 1'b1;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
`ifdef ALU_SEQ_MUL_EN
                    if (op == OP_MUL) begin
                        state_nxt_s = ST_MUL;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
`else
                    state_nxt_s = ST_DONE;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                if (mul_done_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MUL;
                end
`else
                state_nxt_s = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, handshake and output registers; outputs return to zero once consumed
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {W{1'b0}};
            err_r       <= 1'b0;
            flags_r     <= 3'b000;
            taken_r     <= 1'b0;
            baddr_r     <= {W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
            if (accept_s) begin
                result_r <= alu_res_s;
                err_r    <= alu_err_s;
                taken_r  <= alu_taken_s;
                baddr_r  <= alu_taken_s ? link : {W{1'b0}};
                if (op == OP_CMP) begin
                    flags_r <= cmp_flags_s;
                end else begin
                    flags_r <= flags_r;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            else if ((state_r == ST_MUL) && mul_done_s) begin
                result_r <= mul_product_s;
            end
`endif
            else if ((state_r == ST_DONE) && out_ready) begin
                result_r <= {W{1'b0}};
                err_r    <= 1'b0;
                taken_r  <= 1'b0;
                baddr_r  <= {W{1'b0}};
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign result       = result_r;
    assign out_err      = err_r;
    assign flags        = flags_r;
    assign branch_taken = taken_r;
    assign branch_addr  = baddr_r;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq; expectations follow ALU_SEQ_MUL_EN when it is defined.
module tb_alu_seq;
    localparam int W    = 32;
    localparam int SH_W = 6;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic        err;
        logic        taken;
        logic [31:0] addr;
        logic [2:0]  flg;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm;
    logic        highlow;
    logic [31:0] link;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        out_err;
    logic [2:0]  flags;
    logic        branch_taken;
    logic [31:0] branch_addr;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    exp_t mon_e;
    logic [2:0] m_flags = 3'b000;

    alu_seq #(.W(W), .SH_W(SH_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op           (op),
        .a            (a),
        .b            (b),
        .imm          (imm),
        .highlow      (highlow),
        .link         (link),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .out_err      (out_err),
        .flags        (flags),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour, written bit-by-bit rather than with shift operators
    function automatic exp_t model(input logic [5:0] o, input logic [31:0] av, input logic [31:0] bv,
                                   input logic [15:0] iv, input logic hv, input logic [31:0] lv);
        exp_t e;
        logic [63:0] p;
        int amt;
        e = '0;
        e.flg = m_flags;
        amt = int'(bv[5:0]);
        case (o)
            6'd0: e.res = av + bv;
            6'd1: e.res = av + ~bv + 32'd1;
            6'd2: begin
                e.res = av;
                if (amt >= 32) e.res = 32'hFFFF_FFFF;
                else for (int i = 0; i < amt; i++) e.res = {e.res[30:0], 1'b1};
            end
            6'd3: begin
                e.res = av;
                if (amt >= 32) e.res = 32'hFFFF_FFFF;
                else for (int i = 0; i < amt; i++) e.res = {1'b1, e.res[31:1]};
            end
            6'd4: e.res = av;
            6'd5: e.res = hv ? {iv, av[15:0]} : {av[31:16], iv};
            6'd6: begin
                p = {32'd0, av} * {32'd0, bv};
                if (MUL_EN) e.res = p[31:0];
                else e.err = 1'b1;
            end
            6'd7: begin
                e.res = av;
                e.flg = {av > bv, av < bv, av == bv};
            end
            6'd8:  e.taken = 1'b1;
            6'd9:  e.taken = m_flags[0];
            6'd10: e.taken = m_flags[1];
            6'd11: e.taken = m_flags[2];
            default: e.err = 1'b1;
        endcase
        if (e.taken) e.addr = lv;
        return e;
    endfunction

    // Output monitor: every completed handshake is matched against the scoreboard
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check_val("spurious_out", 64'd1, 64'd0);
            end else begin
                mon_e = q.pop_front();
                check_val("result", result, mon_e.res);
                check_val("out_err", out_err, mon_e.err);
                check_val("taken", branch_taken, mon_e.taken);
                check_val("branch_addr", branch_addr, mon_e.addr);
                check_val("flags", flags, mon_e.flg);
            end
        end
    end

    task automatic send(input logic [5:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [15:0] iv, input logic hv, input logic [31:0] lv, input bit track);
        exp_t e;
        int guard;
        int lat;
        int busy_bad;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clock); #1;
            guard++;
        end
        if (!in_ready) check_val("in_ready_timeout", 64'd0, 64'd1);
        op = o; a = av; b = bv; imm = iv; highlow = hv; link = lv; in_valid = 1'b1;
        e = model(o, av, bv, iv, hv, lv);
        m_flags = e.flg;
        if (track) q.push_back(e);
        @(posedge clock); #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        if (track) begin
            lat = 0;
            busy_bad = 0;
            while (lat < 200) begin
                @(negedge clock);
                lat++;
                if (out_valid) break;
                if (in_ready) busy_bad++;
            end
            check_val("latency", lat, (o == 6'd6 && MUL_EN) ? W + 1 : 1);
            if (lat > 1) check_val("in_ready_busy", busy_bad, 0);
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int stray;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = 6'd0; a = 32'd0; b = 32'd0; imm = 16'd0; highlow = 1'b0; link = 32'd0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_result", result, 32'd0);
        check_val("rst_err", out_err, 1'b0);
        check_val("rst_flags", flags, 3'b000);
        check_val("rst_taken", branch_taken, 1'b0);
        check_val("rst_addr", branch_addr, 32'd0);
        @(posedge clock); #1;

        send(6'd0, 32'hFFFF_FFFF, 32'd2, 16'd0, 1'b0, 32'd0, 1'b1);
        send(6'd1, 32'd5, 32'd7, 16'd0, 1'b0, 32'd0, 1'b1);
        send(6'd2, 32'h0000_000F, 32'd4, 16'd0, 1'b0, 32'd0, 1'b1);
        send(6'd3, 32'hF000_0000, 32'd40, 16'd0, 1'b0, 32'd0, 1'b1);
        send(6'd3, 32'h8000_0000, 32'd31, 16'd0, 1'b0, 32'd0, 1'b1);
        send(6'd5, 32'h1234_5678, 32'd0, 16'hABCD, 1'b1, 32'd0, 1'b1);
        send(6'd5, 32'h1234_5678, 32'd0, 16'hABCD, 1'b0, 32'd0, 1'b1);
        send(6'd4, 32'hDEAD_BEEF, 32'd1, 16'd0, 1'b0, 32'd0, 1'b1);
        send(6'd7, 32'd3, 32'd3, 16'd0, 1'b0, 32'd0, 1'b1);
        send(6'd9, 32'd0, 32'd0, 16'd0, 1'b0, 32'h100, 1'b1);
        send(6'd10, 32'd0, 32'd0, 16'd0, 1'b0, 32'h200, 1'b1);
        send(6'd7, 32'd2, 32'd9, 16'd0, 1'b0, 32'd0, 1'b1);
        send(6'd10, 32'd0, 32'd0, 16'd0, 1'b0, 32'h300, 1'b1);
        send(6'd11, 32'd0, 32'd0, 16'd0, 1'b0, 32'h400, 1'b1);
        send(6'd8, 32'd0, 32'd0, 16'd0, 1'b0, 32'h44, 1'b1);
        @(negedge clock);
        check_val("idle_taken", branch_taken, 1'b0);
        check_val("idle_addr", branch_addr, 32'd0);
        @(posedge clock); #1;

        send(6'd6, 32'h0001_0000, 32'h0001_0001, 16'd0, 1'b0, 32'd0, 1'b1);
        send(6'd6, 32'h0000_1234, 32'd0, 16'd0, 1'b0, 32'd0, 1'b1);
        send(6'd6, 32'h89AB_CDEF, 32'h1357_9BDF, 16'd0, 1'b0, 32'd0, 1'b1);
        send(6'h3F, 32'd1, 32'd2, 16'd0, 1'b0, 32'd0, 1'b1);
        send(6'd12, 32'd1, 32'd2, 16'd0, 1'b0, 32'h55, 1'b1);

        for (int i = 0; i < 10; i++) begin
            send(6'($urandom_range(0, 11)), $urandom, $urandom, 16'($urandom),
                 1'($urandom), $urandom, 1'b1);
        end

        // Consumer stall: result held, no new accept
        out_ready = 1'b0;
        send(6'd0, 32'd7, 32'd8, 16'd0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_val("stall_valid", out_valid, 1'b1);
            check_val("stall_result", result, 32'd15);
            check_val("stall_in_ready", in_ready, 1'b0);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        @(posedge clock); #1;

        // Reset while holding a result
        out_ready = 1'b0;
        send(6'd7, 32'd9, 32'd4, 16'd0, 1'b0, 32'd0, 1'b0);
        @(negedge clock);
        check_val("done_valid", out_valid, 1'b1);
        check_val("done_flags", flags, 3'b100);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        out_ready = 1'b1;
        m_flags = 3'b000;
        @(negedge clock);
        check_val("rst_done_valid", out_valid, 1'b0);
        check_val("rst_done_flags", flags, 3'b000);
        check_val("rst_done_result", result, 32'd0);
        check_val("rst_done_in_ready", in_ready, 1'b1);
        @(posedge clock); #1;

`ifdef ALU_SEQ_MUL_EN
        // Reset in the middle of a multiply
        send(6'd7, 32'd5, 32'd3, 16'd0, 1'b0, 32'd0, 1'b1);
        send(6'd6, 32'h0001_0000, 32'h0001_0001, 16'd0, 1'b0, 32'd0, 1'b0);
        repeat (9) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        m_flags = 3'b000;
        stray = 0;
        repeat (40) begin
            @(negedge clock);
            if (out_valid) stray++;
        end
        check_val("mid_mul_no_out", stray, 0);
        check_val("mid_mul_flags", flags, 3'b000);
        @(posedge clock); #1;
`endif

        send(6'd1, 32'd0, 32'd1, 16'd0, 1'b0, 32'd0, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        check_val("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
